word_packer_flex: RTL and testbench

//  Parametrised successor to the UART byte packer: pops DATA_WIDTH symbols from the sync FIFO (FWFT)
//  and assembles WORD_WIDTH words for the word FIFO feeding the AXI/DDR writer. Adds configurable

---
 rtl/word_packer_flex.sv | 127 ++++++++++++
 tb/tb_word_packer_flex.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer_flex.sv
// Packs DATA_WIDTH symbols from a FWFT FIFO into WORD_WIDTH words with lane order, flush and strobes.
// Optional idle auto-flush is compiled in with `define PACKER_FLUSH_TIMEOUT_EN.
module word_packer_flex #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 128,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              check_empty,
  output logic                              read_enable,
  input  logic                              flush_req,
  input  logic                              word_fifo_full,
  output logic [WORD_WIDTH-1:0]             data_out,
  output logic [WORD_WIDTH/DATA_WIDTH-1:0]  byte_strb,
  output logic                              packed_done,
  output logic                              busy,
  output logic [15:0]                       word_count,
  output logic [WORD_WIDTH-1:0]             packer_out
);

  localparam int LANES = WORD_WIDTH / DATA_WIDTH;
  localparam int CW    = $clog2(LANES + 1);

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [WORD_WIDTH-1:0]   asm_q, asm_d;
  logic [LANES-1:0]        strb_q, strb_d;
  logic [WORD_WIDTH-1:0]   data_out_q;
  logic [LANES-1:0]        byte_strb_q;
  logic [15:0]             word_count_q;

  logic                    accept;
  logic [CW-1:0]           lane_idx;
  logic [CW-1:0]           cnt_acc;
  logic                    full_hit;
  logic                    flush_hit;
  logic                    tmo_hit;

  assign accept   = (state_q == FILL) && !check_empty;
  assign lane_idx = LSB_FIRST ? cnt_q : (CW'(LANES - 1) - cnt_q);
  assign cnt_acc  = cnt_q + CW'(accept);
  assign full_hit = accept && (cnt_q == CW'(LANES - 1));
  // A same-cycle accept counts toward the partial word, so flush looks at cnt_acc.
  assign flush_hit = (state_q == FILL) && (flush_req || tmo_hit) && (cnt_acc != '0);

  always_comb begin
    asm_d  = asm_q;
    strb_d = strb_q;
    for (int i = 0; i < LANES; i++) begin
      if (accept && (lane_idx == CW'(i))) begin
        asm_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
        strb_d[i]                         = 1'b1;
      end
    end
  end

`ifdef PACKER_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Fires on the idle cycle whose increment would bring the counter to TIMEOUT_CYCLES-1.
  assign tmo_hit = (state_q == FILL) && !accept && (cnt_q != '0) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if ((state_q != FILL) || accept || (cnt_q == '0) || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      asm_q        <= '0;
      strb_q       <= '0;
      data_out_q   <= '0;
      byte_strb_q  <= '0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (full_hit || flush_hit) begin
            state_q     <= EMIT;
            data_out_q  <= asm_d;
            byte_strb_q <= strb_d;
            asm_q       <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
          end else begin
            asm_q  <= asm_d;
            strb_q <= strb_d;
            cnt_q  <= cnt_acc;
          end
        end
        EMIT: begin
          if (!word_fifo_full) begin
            state_q      <= FILL;
            word_count_q <= word_count_q + 16'd1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign read_enable = accept;
  assign packed_done = (state_q == EMIT) && !word_fifo_full;
  assign busy        = (cnt_q != '0) || (state_q == EMIT);
  assign data_out    = data_out_q;
  assign byte_strb   = byte_strb_q;
  assign word_count  = word_count_q;
  assign packer_out  = asm_q;

endmodule

// File: tb/tb_word_packer_flex.sv
// Scoreboard bench for word_packer_flex: LSB-first and MSB-first instances share one stimulus stream.
// Build with +define+PACKER_FLUSH_TIMEOUT_EN to also exercise the idle auto-flush.
module tb_word_packer_flex;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   data_in = '0;
  logic         check_empty = 1'b1;
  logic         flush_req = 1'b0;
  logic         word_fifo_full = 1'b0;

  logic         read_enable, packed_done, busy;
  logic [127:0] data_out, packer_out;
  logic [15:0]  byte_strb, word_count;

  logic         m_read_enable, m_packed_done, m_busy;
  logic [127:0] m_data_out, m_packer_out;
  logic [15:0]  m_byte_strb, m_word_count;

  word_packer_flex #(.DATA_WIDTH(8), .WORD_WIDTH(128), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .check_empty(check_empty), .read_enable(read_enable),
    .flush_req(flush_req), .word_fifo_full(word_fifo_full), .data_out(data_out), .byte_strb(byte_strb),
    .packed_done(packed_done), .busy(busy), .word_count(word_count), .packer_out(packer_out));

  word_packer_flex #(.DATA_WIDTH(8), .WORD_WIDTH(128), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(8)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .check_empty(check_empty), .read_enable(m_read_enable),
    .flush_req(flush_req), .word_fifo_full(word_fifo_full), .data_out(m_data_out), .byte_strb(m_byte_strb),
    .packed_done(m_packed_done), .busy(m_busy), .word_count(m_word_count), .packer_out(m_packer_out));

  always #5 clk = ~clk;

  typedef struct packed {logic [127:0] w; logic [15:0] s;} exp_t;
  exp_t       exp_l[$];
  exp_t       exp_m[$];
  logic [7:0] m_bytes[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_writes = 0;
  int last_write = 0;
  int first_pop = -1;
  int last_pop = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard pop: every word written by either instance must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (packed_done) begin
        n_writes   = n_writes + 1;
        last_write = cyc;
        n_cmp      = n_cmp + 1;
        if (exp_l.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL lsb_unexpected_write data_out=%h strb=%h", data_out, byte_strb);
        end else begin
          e = exp_l.pop_front();
          if (data_out !== e.w || byte_strb !== e.s) begin
            n_err = n_err + 1;
            $display("FAIL lsb_word got=%h/%h exp=%h/%h", data_out, byte_strb, e.w, e.s);
          end
        end
      end
      if (m_packed_done) begin
        n_cmp = n_cmp + 1;
        if (exp_m.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL msb_unexpected_write data_out=%h strb=%h", m_data_out, m_byte_strb);
        end else begin
          e = exp_m.pop_front();
          if (m_data_out !== e.w || m_byte_strb !== e.s) begin
            n_err = n_err + 1;
            $display("FAIL msb_word got=%h/%h exp=%h/%h", m_data_out, m_byte_strb, e.w, e.s);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_emit();
    exp_t el, em;
    el = '0;
    em = '0;
    for (int i = 0; i < m_bytes.size(); i++) begin
      el.w[i*8 +: 8]      = m_bytes[i];
      el.s[i]             = 1'b1;
      em.w[(15-i)*8 +: 8] = m_bytes[i];
      em.s[15-i]          = 1'b1;
    end
    exp_l.push_back(el);
    exp_m.push_back(em);
    m_bytes.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    check_empty = 1'b1;
    flush_req = 1'b0;
    word_fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_l.delete();
    exp_m.delete();
    m_bytes.delete();
    n_writes = 0;
  endtask

  // Offers one symbol and waits (bounded) until the packer pops it.
  task automatic feed(input logic [7:0] b, input logic fl);
    bit got = 1'b0;
    data_in = b;
    check_empty = 1'b0;
    flush_req = fl;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (read_enable) begin
        got = 1'b1;
        last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
      @(posedge clk);
      #1;
      flush_req = 1'b0;
    end
    check_empty = 1'b1;
    if (!got) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL feed_pop_timeout byte=%h read_enable never rose", b);
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 16) model_emit();
      if (fl && m_bytes.size() > 0) model_emit();
    end
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    if (m_bytes.size() > 0) model_emit();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (data_out !== '0 || byte_strb !== '0 || word_count !== '0 || busy !== 1'b0 ||
        packed_done !== 1'b0 || packer_out !== '0 || read_enable !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_state data_out=%h strb=%h wc=%0d busy=%b done=%b asm=%h re=%b (want all zero)",
               data_out, byte_strb, word_count, busy, packed_done, packer_out, read_enable);
    end
    check_empty = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if (read_enable !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL reset_read_enable got=%b exp=1", read_enable);
    end
    check_empty = 1'b1;
    tick();
  endtask

  task automatic test_full_word_lsb();
    do_reset();
    for (int i = 0; i < 16; i++) feed(8'(i), 1'b0);
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if (data_out !== 128'h0F0E0D0C0B0A09080706050403020100 || byte_strb !== 16'hFFFF) begin
      n_err = n_err + 1;
      $display("FAIL full_lsb data_out=%h strb=%h exp=0F0E..0100/FFFF", data_out, byte_strb);
    end
    n_cmp = n_cmp + 1;
    if (word_count !== 16'd1 || n_writes !== 1 || exp_l.size() !== 0) begin
      n_err = n_err + 1;
      $display("FAIL full_lsb_count wc=%0d writes=%0d pending=%0d exp=1/1/0", word_count, n_writes, exp_l.size());
    end
  endtask

  task automatic test_back_to_back_msb();
    do_reset();
    first_pop = -1;
    for (int i = 0; i < 32; i++) feed(8'(i), 1'b0);
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if (m_data_out !== 128'h101112131415161718191A1B1C1D1E1F || m_byte_strb !== 16'hFFFF) begin
      n_err = n_err + 1;
      $display("FAIL msb_second_word data_out=%h strb=%h exp=1011..1E1F/FFFF", m_data_out, m_byte_strb);
    end
    n_cmp = n_cmp + 1;
    if (last_write - first_pop + 1 !== 34 || n_writes !== 2 || m_word_count !== 16'd2) begin
      n_err = n_err + 1;
      $display("FAIL b2b_timing cycles=%0d writes=%0d wc=%0d exp=34/2/2",
               last_write - first_pop + 1, n_writes, m_word_count);
    end
  endtask

  task automatic test_flush();
    int w0;
    do_reset();
    for (int i = 1; i <= 5; i++) feed(8'hA0 + 8'(i), 1'b0);
`ifndef PACKER_FLUSH_TIMEOUT_EN
    repeat (30) tick();
    n_cmp = n_cmp + 1;
    if (n_writes !== 0 || busy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL idle_no_autoflush writes=%0d busy=%b exp=0/1", n_writes, busy);
    end
`endif
    pulse_flush();
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if (data_out !== 128'h000000000000000000000000A5A4A3A2A1 || byte_strb !== 16'h001F) begin
      n_err = n_err + 1;
      $display("FAIL partial_flush data_out=%h strb=%h exp=..A5A4A3A2A1/001F", data_out, byte_strb);
    end
    w0 = n_writes;
    pulse_flush();
    repeat (5) tick();
    n_cmp = n_cmp + 1;
    if (n_writes !== w0 || busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL empty_flush writes=%0d busy=%b exp=%0d/0", n_writes, busy, w0);
    end
    feed(8'h31, 1'b0);
    feed(8'h32, 1'b0);
    feed(8'h33, 1'b1);
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if (byte_strb !== 16'h0007 || m_byte_strb !== 16'hE000 || exp_l.size() !== 0 || exp_m.size() !== 0) begin
      n_err = n_err + 1;
      $display("FAIL flush_with_accept strb=%h mstrb=%h pending=%0d exp=0007/E000/0",
               byte_strb, m_byte_strb, exp_l.size());
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    do_reset();
    word_fifo_full = 1'b1;
    for (int i = 0; i < 16; i++) feed(8'hC0 + 8'(i), 1'b0);
    held = exp_l[0].w;
    check_empty = 1'b0;
    data_in = 8'h77;
    for (int k = 0; k < 10; k++) begin
      flush_req = (k == 3);
      @(negedge clk);
      n_cmp = n_cmp + 1;
      if (packed_done !== 1'b0 || read_enable !== 1'b0 || data_out !== held) begin
        n_err = n_err + 1;
        $display("FAIL hold_cycle%0d done=%b re=%b data_out=%h exp=0/0/%h", k, packed_done, read_enable, data_out, held);
      end
      @(posedge clk);
      #1;
    end
    flush_req = 1'b0;
    check_empty = 1'b1;
    word_fifo_full = 1'b0;
    repeat (4) tick();
    n_cmp = n_cmp + 1;
    if (n_writes !== 1 || word_count !== 16'd1 || exp_l.size() !== 0) begin
      n_err = n_err + 1;
      $display("FAIL release_write writes=%0d wc=%0d pending=%0d exp=1/1/0", n_writes, word_count, exp_l.size());
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int i = 0; i < 7; i++) feed(8'hE0 + 8'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bytes.delete();
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (busy !== 1'b0 || packer_out !== '0 || word_count !== '0 || byte_strb !== '0) begin
      n_err = n_err + 1;
      $display("FAIL midword_reset busy=%b asm=%h wc=%0d strb=%h exp=0", busy, packer_out, word_count, byte_strb);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) feed(8'h50 + 8'(i), 1'b0);
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if (data_out !== 128'h5F5E5D5C5B5A59585756555453525150 || exp_l.size() !== 0 || word_count !== 16'd1) begin
      n_err = n_err + 1;
      $display("FAIL clean_after_reset data_out=%h wc=%0d exp=5F5E..5150/1", data_out, word_count);
    end
  endtask

`ifdef PACKER_FLUSH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) feed(8'h90 + 8'(i), 1'b0);
    model_emit();
    repeat (14) tick();
    n_cmp = n_cmp + 1;
    if (n_writes !== 1 || last_write - last_pop !== 8 || byte_strb !== 16'h0007 || exp_l.size() !== 0) begin
      n_err = n_err + 1;
      $display("FAIL timeout_flush writes=%0d delay=%0d strb=%h exp=1/8/0007",
               n_writes, last_write - last_pop, byte_strb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_word_lsb();
    test_back_to_back_msb();
    test_flush();
    test_backpressure();
    test_reset_midword();
`ifdef PACKER_FLUSH_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
